spi_cmd_arbiter: RTL and testbench

- Shares one SPI master among N_REQ configuration controllers (e.g. clock-chip config FSM, ADC config FSM).
- Arbitrates between them round-robin and forwards one write or read command at a time.
- Tracks the SPI busy handshake, with a timeout, and returns completion, error and read data to the granted requester.
- Sits between the per-device config FSMs and the single SPI master.

---
 rtl/spi_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI master between several config controllers.
// Forwards one command at a time, tracks the busy handshake with a timeout, and reports back.
module spi_cmd_arbiter #(
    parameter int N_REQ   = 2,
    parameter int MOSI_W  = 24,
    parameter int MISO_W  = 8,
    parameter int BUSY_TO = 1023,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req_wr,
    input  logic [N_REQ-1:0]        i_req_rd,
    input  logic [N_REQ*MOSI_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ack,
    output logic [N_REQ-1:0]        o_req_done,
    output logic [N_REQ-1:0]        o_req_err,
    output logic [MISO_W-1:0]       o_rd_data,
    output logic [ID_W-1:0]         o_grant_id,
    output logic                    o_busy,
    output logic                    o_spi_wr_cmd,
    output logic                    o_spi_rd_cmd,
    output logic [MOSI_W-1:0]       o_spi_wr_data,
    input  logic [MISO_W-1:0]       i_spi_rd_data,
    input  logic                    i_spi_busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   pick;
    logic              pick_vld;
    logic [ID_W:0]     sum;
    logic [N_REQ-1:0]  pending;
    logic [15:0]       timer;
    logic              op_wr;
    logic              tmo;

    logic [N_REQ-1:0]  ack_d, done_d, err_d;
    logic              wr_cmd_d, rd_cmd_d, busy_d;

    // First pending requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        pending  = i_req_wr | i_req_rd;
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            if (!pick_vld && pending[sum[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick     = sum[ID_W-1:0];
            end
        end
    end

    // Timeout only counts when the awaited busy edge has not arrived this cycle.
    assign tmo = (timer >= 16'(BUSY_TO)) &&
                 (((state == WAIT_HI) && !i_spi_busy) || ((state == WAIT_LO) && i_spi_busy));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_vld && !i_spi_busy) state_d = ISSUE;
            ISSUE:   state_d = WAIT_HI;
            WAIT_HI: if (i_spi_busy) state_d = WAIT_LO;
                     else if (tmo)   state_d = DONE;
            WAIT_LO: if (!i_spi_busy || tmo) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        ack_d    = '0;
        done_d   = '0;
        err_d    = '0;
        wr_cmd_d = 1'b0;
        rd_cmd_d = 1'b0;
        busy_d   = (state_d != IDLE);
        if (state_d == ISSUE) begin
            ack_d    = N_REQ'(1) << pick;
            wr_cmd_d = i_req_wr[pick];
            rd_cmd_d = !i_req_wr[pick];
        end
        if (state_d == DONE) begin
            done_d = N_REQ'(1) << o_grant_id;
            if (tmo)
                err_d = N_REQ'(1) << o_grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            timer <= '0;
            op_wr <= 1'b0;
        end else begin
            if (state_d == ISSUE)
                op_wr <= i_req_wr[pick];
            case (state)
                ISSUE: begin
                    timer <= '0;
                    ptr   <= (o_grant_id == ID_W'(N_REQ-1)) ? '0 : o_grant_id + 1'b1;
                end
                WAIT_HI: timer <= i_spi_busy ? '0 : timer + 16'd1;
                WAIT_LO: timer <= timer + 16'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_req_ack     <= '0;
            o_req_done    <= '0;
            o_req_err     <= '0;
            o_rd_data     <= '0;
            o_grant_id    <= '0;
            o_busy        <= 1'b0;
            o_spi_wr_cmd  <= 1'b0;
            o_spi_rd_cmd  <= 1'b0;
            o_spi_wr_data <= '0;
        end else begin
            o_req_ack    <= ack_d;
            o_req_done   <= done_d;
            o_req_err    <= err_d;
            o_busy       <= busy_d;
            o_spi_wr_cmd <= wr_cmd_d;
            o_spi_rd_cmd <= rd_cmd_d;
            if (state_d == ISSUE) begin
                o_spi_wr_data <= i_req_data[pick*MOSI_W +: MOSI_W];
                o_grant_id    <= pick;
            end
            if ((state == WAIT_LO) && !i_spi_busy && !op_wr)
                o_rd_data <= i_spi_rd_data;
        end
    end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter: two requesters, short busy timeout.
module tb_spi_cmd_arbiter;

    localparam int N_REQ   = 2;
    localparam int MOSI_W  = 24;
    localparam int MISO_W  = 8;
    localparam int BUSY_TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_wr = '0;
    logic [1:0]        req_rd = '0;
    logic [47:0]       req_data = '0;
    logic [7:0]        spi_rd_data = '0;
    logic              spi_busy = 1'b0;
    logic [1:0]        o_req_ack, o_req_done, o_req_err;
    logic [7:0]        o_rd_data;
    logic [0:0]        o_grant_id;
    logic              o_busy, o_spi_wr_cmd, o_spi_rd_cmd;
    logic [23:0]       o_spi_wr_data;

    int vectors = 0;
    int miscompares = 0;

    spi_cmd_arbiter #(.N_REQ(N_REQ), .MOSI_W(MOSI_W), .MISO_W(MISO_W), .BUSY_TO(BUSY_TO)) dut (
        .clk(clk), .rst(rst),
        .i_req_wr(req_wr), .i_req_rd(req_rd), .i_req_data(req_data),
        .o_req_ack(o_req_ack), .o_req_done(o_req_done), .o_req_err(o_req_err),
        .o_rd_data(o_rd_data), .o_grant_id(o_grant_id), .o_busy(o_busy),
        .o_spi_wr_cmd(o_spi_wr_cmd), .o_spi_rd_cmd(o_spi_rd_cmd), .o_spi_wr_data(o_spi_wr_data),
        .i_spi_rd_data(spi_rd_data), .i_spi_busy(spi_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // SPI master model, entered with ISSUE visible (cycle 0). Busy is driven high during
    // cycles [hi_start, hi_start+hi_len); returns the cycle on which done was seen.
    task automatic spi_cycle(input int hi_start, input int hi_len, input logic [7:0] rdv,
                             output int done_at, output logic [1:0] done_v,
                             output logic [1:0] err_v, output int n_wr, output int n_rd);
        done_at = -1; done_v = '0; err_v = '0; n_wr = 0; n_rd = 0;
        spi_rd_data = rdv;
        for (int n = 0; n < 60; n++) begin
            if (o_spi_wr_cmd) n_wr++;
            if (o_spi_rd_cmd) n_rd++;
            if (o_req_done != 2'b00) begin
                done_at = n; done_v = o_req_done; err_v = o_req_err;
                break;
            end
            spi_busy = (n >= hi_start) && (n < hi_start + hi_len);
            tick();
        end
        spi_busy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        vectors++; if (o_req_ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b want 00", o_req_ack); end
        vectors++; if (o_req_done !== 2'b00) begin miscompares++; $display("FAIL reset_done: got %b want 00", o_req_done); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        vectors++; if ({o_spi_wr_cmd, o_spi_rd_cmd} !== 2'b00) begin miscompares++; $display("FAIL reset_cmd: got %b want 00", {o_spi_wr_cmd, o_spi_rd_cmd}); end
        vectors++; if (o_spi_wr_data !== 24'h0) begin miscompares++; $display("FAIL reset_wr_data: got %h want 000000", o_spi_wr_data); end
        vectors++; if (o_rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %h want 00", o_rd_data); end
        rst = 1'b0;
        tick();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_write;
        int da, nw, nr; logic [1:0] dv, ev;
        req_data[23:0] = 24'h00140F18;
        req_wr = 2'b01;
        tick();
        vectors++; if (o_req_ack !== 2'b01) begin miscompares++; $display("FAIL wr_ack: got %b want 01", o_req_ack); end
        vectors++; if ({o_spi_wr_cmd, o_spi_rd_cmd} !== 2'b10) begin miscompares++; $display("FAIL wr_strobe: got %b want 10", {o_spi_wr_cmd, o_spi_rd_cmd}); end
        vectors++; if (o_spi_wr_data !== 24'h00140F18) begin miscompares++; $display("FAIL wr_data: got %h want 00140f18", o_spi_wr_data); end
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %b want 1", o_busy); end
        req_wr = 2'b00;
        spi_cycle(2, 10, 8'hEE, da, dv, ev, nw, nr);
        vectors++; if (da !== 13) begin miscompares++; $display("FAIL wr_done_cycle: got %0d want 13", da); end
        vectors++; if ({dv, ev} !== 4'b0100) begin miscompares++; $display("FAIL wr_done_err: got %b want 0100", {dv, ev}); end
        vectors++; if (nw !== 1) begin miscompares++; $display("FAIL wr_strobe_count: got %0d want 1", nw); end
        vectors++; if (o_rd_data !== 8'h00) begin miscompares++; $display("FAIL wr_rd_data_kept: got %h want 00", o_rd_data); end
        tick();
        vectors++; if (o_req_done !== 2'b00) begin miscompares++; $display("FAIL wr_done_pulse: got %b want 00", o_req_done); end
    endtask

    task automatic test_read;
        int da, nw, nr; logic [1:0] dv, ev;
        req_data[47:24] = 24'h008001;
        req_rd = 2'b10;
        tick();
        vectors++; if (o_req_ack !== 2'b10) begin miscompares++; $display("FAIL rd_ack: got %b want 10", o_req_ack); end
        vectors++; if (o_grant_id !== 1'b1) begin miscompares++; $display("FAIL rd_grant: got %0d want 1", o_grant_id); end
        vectors++; if (o_spi_wr_data !== 24'h008001) begin miscompares++; $display("FAIL rd_word: got %h want 008001", o_spi_wr_data); end
        req_rd = 2'b00;
        spi_cycle(2, 10, 8'h6A, da, dv, ev, nw, nr);
        vectors++; if ({dv, ev} !== 4'b1000) begin miscompares++; $display("FAIL rd_done_err: got %b want 1000", {dv, ev}); end
        vectors++; if ({nw[3:0], nr[3:0]} !== 8'h01) begin miscompares++; $display("FAIL rd_strobes: got wr=%0d rd=%0d want wr=0 rd=1", nw, nr); end
        vectors++; if (o_rd_data !== 8'h6A) begin miscompares++; $display("FAIL rd_data: got %h want 6a", o_rd_data); end
        tick();
    endtask

    task automatic test_round_robin;
        int da, nw, nr, g; logic [1:0] dv, ev; logic [23:0] w;
        req_data = {24'hB00002, 24'hA00001};
        req_wr = 2'b11;
        for (int t = 0; t < 4; t++) begin
            g = t % 2;
            w = (g == 0) ? 24'hA00001 : 24'hB00002;
            if (t > 0) tick();
            tick();
            vectors++; if (o_req_ack !== 2'(1 << g)) begin miscompares++; $display("FAIL rr_ack_%0d: got %b want %b", t, o_req_ack, 2'(1 << g)); end
            vectors++; if (o_spi_wr_data !== w) begin miscompares++; $display("FAIL rr_word_%0d: got %h want %h", t, o_spi_wr_data, w); end
            req_wr[g] = 1'b0;
            spi_cycle(2, 10, 8'h00, da, dv, ev, nw, nr);
            vectors++; if (dv !== 2'(1 << g)) begin miscompares++; $display("FAIL rr_done_%0d: got %b want %b", t, dv, 2'(1 << g)); end
            if (t < 3) req_wr[g] = 1'b1;
            else req_wr = 2'b00;
        end
        tick();
    endtask

    task automatic test_timeout;
        int da, nw, nr; logic [1:0] dv, ev;
        req_rd = 2'b01;
        tick();
        vectors++; if (o_req_ack !== 2'b01) begin miscompares++; $display("FAIL to_ack: got %b want 01", o_req_ack); end
        req_rd = 2'b00;
        spi_cycle(0, 0, 8'h55, da, dv, ev, nw, nr);
        vectors++; if (da !== 18) begin miscompares++; $display("FAIL to_done_cycle: got %0d want 18", da); end
        vectors++; if ({dv, ev} !== 4'b0101) begin miscompares++; $display("FAIL to_done_err: got %b want 0101", {dv, ev}); end
        vectors++; if (o_rd_data !== 8'h6A) begin miscompares++; $display("FAIL to_rd_data_kept: got %h want 6a", o_rd_data); end
        tick();
        req_rd = 2'b10;
        tick();
        vectors++; if (o_req_ack !== 2'b10) begin miscompares++; $display("FAIL to_next_ack: got %b want 10", o_req_ack); end
        req_rd = 2'b00;
        spi_cycle(2, 10, 8'hC3, da, dv, ev, nw, nr);
        vectors++; if ({dv, ev} !== 4'b1000) begin miscompares++; $display("FAIL to_next_done: got %b want 1000", {dv, ev}); end
        vectors++; if (o_rd_data !== 8'hC3) begin miscompares++; $display("FAIL to_next_rd_data: got %h want c3", o_rd_data); end
        tick();
    endtask

    task automatic test_busy_hold;
        int da, nw, nr; logic [1:0] dv, ev;
        spi_busy = 1'b1;
        req_data[23:0] = 24'h123456;
        req_wr = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if ({o_req_ack, o_busy} !== 3'b000) begin miscompares++; $display("FAIL bh_no_ack_%0d: got %b want 000", i, {o_req_ack, o_busy}); end
        end
        spi_busy = 1'b0;
        tick();
        vectors++; if (o_req_ack !== 2'b01) begin miscompares++; $display("FAIL bh_ack: got %b want 01", o_req_ack); end
        vectors++; if (o_spi_wr_data !== 24'h123456) begin miscompares++; $display("FAIL bh_word: got %h want 123456", o_spi_wr_data); end
        req_wr = 2'b00;
        spi_cycle(2, 10, 8'h00, da, dv, ev, nw, nr);
        vectors++; if ({dv, ev} !== 4'b0100) begin miscompares++; $display("FAIL bh_done: got %b want 0100", {dv, ev}); end
        tick();
    endtask

    task automatic test_reset_mid;
        int da, nw, nr; logic [1:0] dv, ev;
        req_wr = 2'b01;
        tick();
        req_wr = 2'b00;
        spi_busy = 1'b1;
        tick(); tick(); tick();
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL rm_busy_before: got %b want 1", o_busy); end
        rst = 1'b1;
        tick();
        vectors++; if ({o_req_ack, o_req_done, o_req_err, o_busy, o_spi_wr_cmd, o_spi_rd_cmd} !== 9'b0) begin miscompares++; $display("FAIL rm_ctrl_zero: got %b want 000000000", {o_req_ack, o_req_done, o_req_err, o_busy, o_spi_wr_cmd, o_spi_rd_cmd}); end
        vectors++; if ({o_spi_wr_data, o_rd_data, o_grant_id} !== 33'b0) begin miscompares++; $display("FAIL rm_data_zero: got %h want 0", {o_spi_wr_data, o_rd_data, o_grant_id}); end
        rst = 1'b0;
        spi_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if ({o_req_done, o_req_err} !== 4'b0) begin miscompares++; $display("FAIL rm_no_done_%0d: got %b want 0000", i, {o_req_done, o_req_err}); end
        end
        req_rd = 2'b10;
        tick();
        vectors++; if ({o_req_ack, o_grant_id} !== 3'b101) begin miscompares++; $display("FAIL rm_req1_grant: got %b want 101", {o_req_ack, o_grant_id}); end
        req_rd = 2'b00;
        spi_cycle(2, 10, 8'h3C, da, dv, ev, nw, nr);
        vectors++; if (o_rd_data !== 8'h3C) begin miscompares++; $display("FAIL rm_rd_data: got %h want 3c", o_rd_data); end
        tick();
        // Leave the pointer at 1, reset mid-wait, then both pending must go to requester 0.
        req_wr = 2'b01;
        tick();
        req_wr = 2'b00;
        spi_busy = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spi_busy = 1'b0;
        req_wr = 2'b11;
        tick();
        vectors++; if (o_req_ack !== 2'b01) begin miscompares++; $display("FAIL rm_ptr_cleared: got %b want 01", o_req_ack); end
        req_wr = 2'b00;
        spi_cycle(2, 10, 8'h00, da, dv, ev, nw, nr);
        vectors++; if (dv !== 2'b01) begin miscompares++; $display("FAIL rm_final_done: got %b want 01", dv); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
